viterbi_sequencer: RTL and testbench



---
 rtl/viterbi_sequencer.sv | 145 ++++++++++++++
 tb/tb_viterbi_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_sequencer.sv
// rtl/viterbi_sequencer.sv - Viterbi POS-tagging trellis control sequencer
module viterbi_sequencer #(
    parameter int NUM_TAGS  = 3,
    parameter int MAX_WORDS = 16,
    parameter int TAG_W     = 2,
    parameter int WORD_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W:0]   num_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              init_en,
    output logic              clear_max,
    output logic              trans_en,
    output logic              first_prev,
    output logic              emit_en,
    output logic              write_en,
    output logic              final_en,
    output logic              bt_load,
    output logic              bt_step,
    output logic [WORD_W-1:0] word_idx,
    output logic [TAG_W-1:0]  cur_tag,
    output logic [TAG_W-1:0]  prev_tag
);

    localparam int NW = WORD_W + 1;
    localparam logic [TAG_W-1:0] TAG_LAST  = TAG_W'(NUM_TAGS - 1);
    localparam logic [NW-1:0]    WORDS_MAX = NW'(MAX_WORDS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_INIT, ST_CLEAR, ST_TRANS, ST_EMIT,
        ST_WRITE, ST_FIND_MAX, ST_BT_LOAD, ST_BT_STEP, ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      n_q;
    logic [WORD_W-1:0]  word_q;
    logic [TAG_W-1:0]   cur_q, prev_q;
    logic               error_q;

    logic               len_ok, n_is_one, word_is_last;
    logic               cur_is_last, prev_is_last, word_is_one;

    assign len_ok       = (num_words != '0) && (num_words <= WORDS_MAX);
    assign n_is_one     = (n_q == NW'(1));
    assign word_is_last = ({1'b0, word_q} == (n_q - NW'(1)));
    assign word_is_one  = (word_q == WORD_W'(1));
    assign cur_is_last  = (cur_q == TAG_LAST);
    assign prev_is_last = (prev_q == TAG_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start && len_ok) state_d = ST_INIT;
            ST_INIT:     if (cur_is_last) state_d = n_is_one ? ST_FIND_MAX : ST_CLEAR;
            ST_CLEAR:    state_d = ST_TRANS;
            ST_TRANS:    if (prev_is_last) state_d = ST_EMIT;
            ST_EMIT:     state_d = ST_WRITE;
            ST_WRITE:    state_d = (cur_is_last && word_is_last) ? ST_FIND_MAX : ST_CLEAR;
            ST_FIND_MAX: if (cur_is_last) state_d = ST_BT_LOAD;
            ST_BT_LOAD:  state_d = n_is_one ? ST_DONE : ST_BT_STEP;
            ST_BT_STEP:  if (word_is_one) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // abort overrides every transition once a run is in flight
        if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            word_q  <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                word_q <= '0;
                cur_q  <= '0;
                prev_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (len_ok) begin
                                n_q    <= num_words;
                                word_q <= '0;
                                cur_q  <= '0;
                                prev_q <= '0;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    ST_INIT: begin
                        if (cur_is_last) begin
                            cur_q <= '0;
                            if (!n_is_one) word_q <= WORD_W'(1);
                        end else begin
                            cur_q <= cur_q + TAG_W'(1);
                        end
                    end
                    ST_CLEAR: prev_q <= '0;
                    ST_TRANS: prev_q <= prev_is_last ? '0 : prev_q + TAG_W'(1);
                    ST_WRITE: begin
                        if (!cur_is_last) begin
                            cur_q <= cur_q + TAG_W'(1);
                        end else begin
                            cur_q <= '0;
                            if (!word_is_last) word_q <= word_q + WORD_W'(1);
                        end
                    end
                    ST_FIND_MAX: if (!cur_is_last) cur_q <= cur_q + TAG_W'(1);
                    ST_BT_STEP:  if (!word_is_one) word_q <= word_q - WORD_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign error      = error_q;
    assign init_en    = (state_q == ST_INIT);
    assign clear_max  = (state_q == ST_CLEAR);
    assign trans_en   = (state_q == ST_TRANS);
    assign first_prev = (state_q == ST_TRANS) && (prev_q == '0);
    assign emit_en    = (state_q == ST_EMIT);
    assign write_en   = (state_q == ST_WRITE);
    assign final_en   = (state_q == ST_FIND_MAX);
    assign bt_load    = (state_q == ST_BT_LOAD);
    assign bt_step    = (state_q == ST_BT_STEP);
    assign word_idx   = word_q;
    assign cur_tag    = cur_q;
    assign prev_tag   = prev_q;

endmodule

// File: tb/tb_viterbi_sequencer.sv
// tb/tb_viterbi_sequencer.sv - directed self-checking bench for viterbi_sequencer
module tb_viterbi_sequencer;

    localparam int T = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] num_words = '0;
    logic       busy, done, error, init_en, clear_max, trans_en, first_prev;
    logic       emit_en, write_en, final_en, bt_load, bt_step;
    logic [3:0] word_idx;
    logic [1:0] cur_tag, prev_tag;

    int total = 0;
    int bad = 0;

    int c_cycles, c_init, c_trans, c_fp, c_write, c_final, c_bt, c_bt_last;
    int c_onehot_err, c_fp_err, c_bt_err, c_write_badword, c_final_badword;
    int c_fin;

    viterbi_sequencer #(
        .NUM_TAGS(T), .MAX_WORDS(16), .TAG_W(2), .WORD_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words), .abort(abort),
        .busy(busy), .done(done), .error(error), .init_en(init_en), .clear_max(clear_max),
        .trans_en(trans_en), .first_prev(first_prev), .emit_en(emit_en), .write_en(write_en),
        .final_en(final_en), .bt_load(bt_load), .bt_step(bt_step), .word_idx(word_idx),
        .cur_tag(cur_tag), .prev_tag(prev_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] strobes();
        return {init_en, clear_max, trans_en, emit_en, write_en, final_en, bt_load, bt_step, done};
    endfunction

    // Starts a run at the current negedge and profiles it; returns at the DONE cycle.
    task automatic run_collect(input int n);
        int exp_bt;
        c_cycles = 0; c_init = 0; c_trans = 0; c_fp = 0; c_write = 0; c_final = 0;
        c_bt = 0; c_bt_last = -1; c_onehot_err = 0; c_fp_err = 0; c_bt_err = 0;
        c_write_badword = 0; c_final_badword = 0; c_fin = 0;
        start = 1'b1;
        num_words = 5'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            c_cycles++;
            if (done) begin
                if ($countones(strobes()) != 1) c_onehot_err++;
                c_fin = 1;
                break;
            end
            if ($countones(strobes()) != 1) c_onehot_err++;
            if (first_prev !== (trans_en && prev_tag == 2'd0)) c_fp_err++;
            if (init_en) c_init++;
            if (trans_en) c_trans++;
            if (first_prev) c_fp++;
            if (write_en) begin
                c_write++;
                if (word_idx == 4'd0 || int'(word_idx) > n - 1) c_write_badword++;
            end
            if (final_en) begin
                c_final++;
                if (int'(word_idx) != n - 1) c_final_badword++;
            end
            if (bt_step) begin
                exp_bt = (c_bt == 0) ? n - 1 : c_bt_last - 1;
                if (int'(word_idx) != exp_bt) c_bt_err++;
                c_bt_last = int'(word_idx);
                c_bt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, error, strobes(), first_prev} !== 12'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {busy, error, strobes(), first_prev});
        end
        total++;
        if ({word_idx, cur_tag, prev_tag} !== 8'b0) begin
            bad++;
            $display("FAIL reset_indices got=%h want=0", {word_idx, cur_tag, prev_tag});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [8:0] ev [8] = '{9'h100, 9'h100, 9'h100, 9'h008, 9'h008, 9'h008, 9'h004, 9'h001};
        int         ec [6] = '{0, 1, 2, 0, 1, 2};
        start = 1'b1;
        num_words = 5'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (strobes() !== ev[i] || busy !== 1'b1 || word_idx !== 4'd0) begin
                bad++;
                $display("FAIL n1_cycle%0d got strobes=%h busy=%b word=%0d want strobes=%h busy=1 word=0",
                         i, strobes(), busy, word_idx, ev[i]);
            end
            if (i < 6) begin
                total++;
                if (int'(cur_tag) != ec[i]) begin
                    bad++;
                    $display("FAIL n1_cur%0d got=%0d want=%0d", i, cur_tag, ec[i]);
                end
            end
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL n1_end got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_two_words();
        run_collect(2);
        total++;
        if (c_fin != 1 || c_cycles != 27) begin
            bad++;
            $display("FAIL n2_cycles got fin=%0d cycles=%0d want fin=1 cycles=27", c_fin, c_cycles);
        end
        total++;
        if (c_write != 3 || c_write_badword != 0) begin
            bad++;
            $display("FAIL n2_write got count=%0d badword=%0d want 3 0", c_write, c_write_badword);
        end
        total++;
        if (c_trans != 9 || c_fp != 3 || c_fp_err != 0) begin
            bad++;
            $display("FAIL n2_trans got trans=%0d fp=%0d fperr=%0d want 9 3 0", c_trans, c_fp, c_fp_err);
        end
        total++;
        if (c_bt != 1 || c_bt_err != 0 || c_bt_last != 1) begin
            bad++;
            $display("FAIL n2_bt got count=%0d err=%0d last=%0d want 1 0 1", c_bt, c_bt_err, c_bt_last);
        end
        total++;
        if (c_init != 3 || c_final != 3 || c_onehot_err != 0) begin
            bad++;
            $display("FAIL n2_misc got init=%0d final=%0d onehot_err=%0d want 3 3 0",
                     c_init, c_final, c_onehot_err);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL n2_end got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_bad_length();
        logic [4:0] bl [3] = '{5'd0, 5'd17, 5'd31};
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            num_words = bl[k];
            @(negedge clk);
            start = 1'b0;
            total++;
            if (error !== 1'b1 || busy !== 1'b0 || strobes() !== 9'h0) begin
                bad++;
                $display("FAIL badlen%0d_pulse got err=%b busy=%b strobes=%h want 1 0 0",
                         bl[k], error, busy, strobes());
            end
            @(negedge clk);
            total++;
            if (error !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL badlen%0d_after got err=%b busy=%b want 0 0", bl[k], error, busy);
            end
        end
    endtask

    task automatic test_abort();
        int tcount = 0;
        int dpulse = 0;
        int found = 0;
        start = 1'b1;
        num_words = 5'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) dpulse++;
            if (trans_en) tcount++;
            if (trans_en && tcount == 5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (found != 1 || word_idx !== 4'd1 || cur_tag !== 2'd1 || prev_tag !== 2'd1) begin
            bad++;
            $display("FAIL abort_point got found=%0d w=%0d c=%0d p=%0d want 1 1 1 1",
                     found, word_idx, cur_tag, prev_tag);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) dpulse++;
            total++;
            if (busy !== 1'b0 || strobes() !== 9'h0 || {word_idx, cur_tag, prev_tag} !== 8'h0) begin
                bad++;
                $display("FAIL abort_idle%0d got busy=%b strobes=%h idx=%h want 0 0 0",
                         i, busy, strobes(), {word_idx, cur_tag, prev_tag});
            end
            @(negedge clk);
        end
        total++;
        if (dpulse != 0) begin
            bad++;
            $display("FAIL abort_done got=%0d want=0", dpulse);
        end
        run_collect(4);
        total++;
        if (c_fin != 1 || c_cycles != 65 || c_write != 9 || c_bt != 3 || c_bt_err != 0) begin
            bad++;
            $display("FAIL abort_rerun got fin=%0d cyc=%0d wr=%0d bt=%0d bterr=%0d want 1 65 9 3 0",
                     c_fin, c_cycles, c_write, c_bt, c_bt_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bt();
        int found = 0;
        int got_done = 0;
        start = 1'b1;
        num_words = 5'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bt_step) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (found != 1) begin
            bad++;
            $display("FAIL rst_bt_reach got=0 want=1");
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, error, strobes(), first_prev} !== 12'b0 || {word_idx, cur_tag, prev_tag} !== 8'h0) begin
            bad++;
            $display("FAIL rst_bt_clear got out=%b idx=%h want 0 0",
                     {busy, error, strobes(), first_prev}, {word_idx, cur_tag, prev_tag});
        end
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (init_en !== 1'b1 || busy !== 1'b1 || cur_tag !== 2'd0 || word_idx !== 4'd0) begin
            bad++;
            $display("FAIL rst_bt_restart got init=%b busy=%b cur=%0d word=%0d want 1 1 0 0",
                     init_en, busy, cur_tag, word_idx);
        end
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (got_done != 1) begin
            bad++;
            $display("FAIL rst_bt_finish got=0 want=1");
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc = 1;
        int got_done = 0;
        run_collect(2);
        total++;
        if (c_fin != 1) begin
            bad++;
            $display("FAIL b2b_first got fin=%0d want 1", c_fin);
        end
        start = 1'b1;
        num_words = 5'd1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (init_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept got init=%b busy=%b want 1 1", init_en, busy);
        end
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got_done != 1 || cyc != 8) begin
            bad++;
            $display("FAIL b2b_second got done=%0d cycles=%0d want 1 8", got_done, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_random_lengths();
        int n;
        int exp_cyc;
        for (int k = 0; k < 5; k++) begin
            n = (k == 0) ? 16 : int'($urandom_range(1, 16));
            exp_cyc = 2 * T + (n - 1) * T * (T + 3) + (n - 1) + 2;
            run_collect(n);
            total++;
            if (c_fin != 1 || c_cycles != exp_cyc) begin
                bad++;
                $display("FAIL rnd_n%0d_cycles got fin=%0d cycles=%0d want 1 %0d", n, c_fin, c_cycles, exp_cyc);
            end
            total++;
            if (c_onehot_err != 0 || c_fp_err != 0 || c_bt_err != 0 || c_final_badword != 0 || c_write_badword != 0) begin
                bad++;
                $display("FAIL rnd_n%0d_checks got oh=%0d fp=%0d bt=%0d fin=%0d wr=%0d want all 0",
                         n, c_onehot_err, c_fp_err, c_bt_err, c_final_badword, c_write_badword);
            end
            total++;
            if (c_bt != n - 1 || c_write != T * (n - 1) || c_final != T || c_trans != T * T * (n - 1)) begin
                bad++;
                $display("FAIL rnd_n%0d_counts got bt=%0d wr=%0d fin=%0d tr=%0d want %0d %0d %0d %0d",
                         n, c_bt, c_write, c_final, c_trans, n - 1, T * (n - 1), T, T * T * (n - 1));
            end
            if (n > 1) begin
                total++;
                if (c_bt_last != 1) begin
                    bad++;
                    $display("FAIL rnd_n%0d_btlast got=%0d want=1", n, c_bt_last);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_bad_length();
        test_abort();
        test_reset_mid_bt();
        test_back_to_back();
        test_random_lengths();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
